// File: rtl/change_dispenser_if.sv
// change_dispenser_if
//  Connects the vend core (master) to the change dispenser (slave).
//  master drives : start, change_amt, refill
//  slave drives  : busy, quarter_out, halfDollar_out, done, fault,
//                  remaining, qtr_stock, half_stock
//  AMT_W / INV_W must match the parameters of the attached change_dispenser.
interface change_dispenser_if #(
  parameter int AMT_W = 3,
  parameter int INV_W = 4
) ();
  logic             start;
  logic [AMT_W-1:0] change_amt;
  logic             refill;
  logic             busy;
  logic             quarter_out;
  logic             halfDollar_out;
  logic             done;
  logic             fault;
  logic [AMT_W-1:0] remaining;
  logic [INV_W-1:0] qtr_stock;
  logic [INV_W-1:0] half_stock;

  modport master (
    output start, change_amt, refill,
    input  busy, quarter_out, halfDollar_out, done, fault,
           remaining, qtr_stock, half_stock
  );

  modport slave (
    input  start, change_amt, refill,
    output busy, quarter_out, halfDollar_out, done, fault,
           remaining, qtr_stock, half_stock
  );
endinterface

// File: rtl/change_dispenser.sv
// change_dispenser
//  Pays out the change owed after a sale as timed coin-eject pulses, largest
//  coin first, while tracking the on-board quarter and half-dollar stock.
//  Reports done (one-cycle pulse) or a sticky fault when stock runs out.
// Ports
//  CLK  in  system clock
//  RES  in  synchronous reset, active-high; overrides any sequence in flight
//  bus  slave side of change_dispenser_if:
//       start/change_amt/refill in; busy, quarter_out, halfDollar_out, done,
//       fault, remaining, qtr_stock, half_stock out (all registered)
module change_dispenser #(
  parameter int AMT_W     = 3,
  parameter int INV_W     = 4,
  parameter int PULSE_CYC = 4,
  parameter int GAP_CYC   = 2,
  parameter int QTR_INIT  = 8,
  parameter int HALF_INIT = 4
) (
  input  logic              CLK,
  input  logic              RES,
  change_dispenser_if.slave bus
);

  // One down-counter times both the pulse and the gap phases.
  localparam int CNT_MAX = (PULSE_CYC > GAP_CYC) ? PULSE_CYC : GAP_CYC;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_CYC - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'(GAP_CYC - 1);
  localparam logic [INV_W-1:0] QTR_FULL   = INV_W'(QTR_INIT);
  localparam logic [INV_W-1:0] HALF_FULL  = INV_W'(HALF_INIT);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PICK  = 3'd1,
    PULSE = 3'd2,
    GAP   = 3'd3,
    DONE  = 3'd4,
    FAULT = 3'd5
  } state_t;

  typedef enum logic {
    COIN_QTR  = 1'b0,
    COIN_HALF = 1'b1
  } coin_t;

  state_t           state_q, state_d;
  coin_t            coin_q,  coin_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic [AMT_W-1:0] rem_q,   rem_d;
  logic [INV_W-1:0] qtr_q,   qtr_d;
  logic [INV_W-1:0] half_q,  half_d;
  logic             fault_q, fault_d;
  logic             busy_q, qtr_out_q, half_out_q, done_q;

  // Next-state and datapath updates.
  always_comb begin
    // NOTE: every signal gets its hold value first so no path leaves one
    // unassigned; a missing default here would infer a latch.
    state_d = state_q;
    coin_d  = coin_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    qtr_d   = qtr_q;
    half_d  = half_q;
    fault_d = fault_q;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          // start wins over a simultaneous refill.
          rem_d   = bus.change_amt;
          fault_d = 1'b0;
          state_d = PICK;
        end else if (bus.refill) begin
          qtr_d  = QTR_FULL;
          half_d = HALF_FULL;
        end
      end

      PICK: begin
        // Stock is only decremented behind a non-zero check, so it cannot wrap.
        if (rem_q >= AMT_W'(2) && half_q != '0) begin
          coin_d  = COIN_HALF;
          rem_d   = rem_q - AMT_W'(2);
          half_d  = half_q - INV_W'(1);
          cnt_d   = PULSE_LOAD;
          state_d = PULSE;
        end else if (rem_q != '0 && qtr_q != '0) begin
          coin_d  = COIN_QTR;
          rem_d   = rem_q - AMT_W'(1);
          qtr_d   = qtr_q - INV_W'(1);
          cnt_d   = PULSE_LOAD;
          state_d = PULSE;
        end else if (rem_q == '0) begin
          state_d = DONE;
        end else begin
          // Owed amount cannot be made from what is left; remaining keeps it.
          fault_d = 1'b1;
          state_d = FAULT;
        end
      end

      PULSE: begin
        if (cnt_q == '0) begin
          cnt_d   = GAP_LOAD;
          state_d = GAP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      GAP: begin
        if (cnt_q == '0) state_d = PICK;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end

      DONE:    state_d = IDLE;
      FAULT:   state_d = IDLE;
      default: state_d = IDLE;  // unused encodings recover
    endcase
  end

  // State, datapath and output registers. Outputs are decoded from the next
  // state so they line up with the state they describe.
  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (RES) begin
      state_q    <= IDLE;
      coin_q     <= COIN_QTR;
      cnt_q      <= '0;
      rem_q      <= '0;
      qtr_q      <= QTR_FULL;
      half_q     <= HALF_FULL;
      fault_q    <= 1'b0;
      busy_q     <= 1'b0;
      qtr_out_q  <= 1'b0;
      half_out_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      coin_q     <= coin_d;
      cnt_q      <= cnt_d;
      rem_q      <= rem_d;
      qtr_q      <= qtr_d;
      half_q     <= half_d;
      fault_q    <= fault_d;
      busy_q     <= (state_d == PICK) || (state_d == PULSE) || (state_d == GAP);
      qtr_out_q  <= (state_d == PULSE) && (coin_d == COIN_QTR);
      half_out_q <= (state_d == PULSE) && (coin_d == COIN_HALF);
      done_q     <= (state_d == DONE);
    end
  end

  assign bus.busy           = busy_q;
  assign bus.quarter_out    = qtr_out_q;
  assign bus.halfDollar_out = half_out_q;
  assign bus.done           = done_q;
  assign bus.fault          = fault_q;
  assign bus.remaining      = rem_q;
  assign bus.qtr_stock      = qtr_q;
  assign bus.half_stock     = half_q;

endmodule

// File: tb/tb_change_dispenser.sv
// tb_change_dispenser
//  Table of directed dispense runs with hand-computed coin counts, stock and
//  timing, plus hand-written sequences for refill/fault interplay and reset
//  in the middle of a coin pulse.
module tb_change_dispenser;

  localparam int PULSE_CYC = 4;
  localparam int GAP_CYC   = 2;
  localparam int COIN_CYC  = PULSE_CYC + GAP_CYC + 1;

  logic CLK = 1'b0;
  logic RES = 1'b1;

  change_dispenser_if #(.AMT_W(3), .INV_W(4)) bus ();

  change_dispenser #(
    .AMT_W(3), .INV_W(4), .PULSE_CYC(PULSE_CYC), .GAP_CYC(GAP_CYC),
    .QTR_INIT(8), .HALF_INIT(4)
  ) dut (
    .CLK (CLK),
    .RES (RES),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // pre: 0 none, 1 reset first, 2 refill first.
  // poke: at cycle poke_cyc (0 = never) drive start with poke_amt and refill.
  typedef struct {
    int pre;
    int amt;
    int start_refill;
    int poke_cyc;
    int poke_amt;
    int exp_nh;
    int exp_nq;
    int exp_done;
    int exp_fault;
    int exp_rem;
    int exp_q;
    int exp_h;
  } vec_t;

  vec_t vecs[20];

  task automatic do_reset();
    RES = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    RES = 1'b0;
  endtask

  task automatic do_refill();
    bus.refill = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    bus.refill = 1'b0;
  endtask

  // Called at a negedge with the DUT in IDLE; returns at a negedge in IDLE.
  task automatic run_txn(input string tag, input int amt, input int start_refill,
                         input int poke_cyc, input int poke_amt,
                         input int exp_nh, input int exp_nq, input int exp_done,
                         input int exp_fault, input int exp_rem,
                         input int exp_q, input int exp_h);
    int cyc, hi_h, hi_q, both, first_h, first_q, term, saw_done, saw_fault;
    int exp_term;
    cyc = 0; hi_h = 0; hi_q = 0; both = 0; first_h = 0; first_q = 0;
    term = 0; saw_done = 0; saw_fault = 0;
    bus.start      = 1'b1;
    bus.change_amt = 3'(amt);
    bus.refill     = (start_refill != 0);
    @(posedge CLK);
    while (term == 0 && cyc < 200) begin
      @(negedge CLK);
      cyc++;
      bus.start  = 1'b0;
      bus.refill = 1'b0;
      if (cyc == poke_cyc) begin
        bus.start      = 1'b1;
        bus.refill     = 1'b1;
        bus.change_amt = 3'(poke_amt);
      end
      if (cyc == 1) begin
        check({tag, " busy@1"}, 32'(bus.busy), 1);
        check({tag, " fault@1"}, 32'(bus.fault), 0);
      end
      if (bus.halfDollar_out === 1'b1) begin
        hi_h++;
        if (first_h == 0) first_h = cyc;
      end
      if (bus.quarter_out === 1'b1) begin
        hi_q++;
        if (first_q == 0) first_q = cyc;
      end
      if (bus.halfDollar_out === 1'b1 && bus.quarter_out === 1'b1) both++;
      if (bus.done === 1'b1 || bus.fault === 1'b1) begin
        term      = cyc;
        saw_done  = int'(bus.done);
        saw_fault = int'(bus.fault);
        check({tag, " remaining"}, 32'(bus.remaining), exp_rem);
        check({tag, " qtr_stock"}, 32'(bus.qtr_stock), exp_q);
        check({tag, " half_stock"}, 32'(bus.half_stock), exp_h);
        check({tag, " busy@end"}, 32'(bus.busy), 0);
      end
    end
    if (term == 0) begin
      check({tag, " timeout"}, 0, 1);
    end else begin
      exp_term = 2 + COIN_CYC * (exp_nh + exp_nq);
      check({tag, " end_cycle"}, term, exp_term);
      check({tag, " done"}, saw_done, exp_done);
      check({tag, " fault"}, saw_fault, exp_fault);
      check({tag, " half_hi_cycles"}, hi_h, exp_nh * PULSE_CYC);
      check({tag, " qtr_hi_cycles"}, hi_q, exp_nq * PULSE_CYC);
      check({tag, " both_high"}, both, 0);
      check({tag, " first_half"}, first_h, (exp_nh > 0) ? 2 : 0);
      check({tag, " first_qtr"}, first_q, (exp_nq > 0) ? 2 + COIN_CYC * exp_nh : 0);
      @(negedge CLK);
      check({tag, " done_one_cycle"}, 32'(bus.done), 0);
    end
  endtask

  initial begin
    bus.start      = 1'b0;
    bus.change_amt = '0;
    bus.refill     = 1'b0;

    // pre amt srf poke pamt  nh nq done fault rem  q  h
    vecs[0]  = '{1, 3, 0, 0, 0,  1, 1, 1, 0, 0, 7, 3};
    vecs[1]  = '{1, 0, 0, 0, 0,  0, 0, 1, 0, 0, 8, 4};
    vecs[2]  = '{1, 7, 0, 0, 0,  3, 1, 1, 0, 0, 7, 1};
    vecs[3]  = '{0, 2, 0, 4, 5,  1, 0, 1, 0, 0, 7, 0};
    vecs[4]  = '{0, 0, 1, 0, 0,  0, 0, 1, 0, 0, 7, 0};
    vecs[5]  = '{1, 2, 0, 0, 0,  1, 0, 1, 0, 0, 8, 3};
    vecs[6]  = '{0, 2, 0, 0, 0,  1, 0, 1, 0, 0, 8, 2};
    vecs[7]  = '{0, 2, 0, 0, 0,  1, 0, 1, 0, 0, 8, 1};
    vecs[8]  = '{0, 2, 0, 0, 0,  1, 0, 1, 0, 0, 8, 0};
    vecs[9]  = '{0, 2, 0, 0, 0,  0, 2, 1, 0, 0, 6, 0};
    vecs[10] = '{2, 1, 0, 0, 0,  0, 1, 1, 0, 0, 7, 4};
    for (int i = 0; i < 6; i++)
      vecs[11 + i] = '{0, 1, 0, 0, 0,  0, 1, 1, 0, 0, 6 - i, 4};
    vecs[17] = '{0, 3, 0, 0, 0,  1, 1, 1, 0, 0, 0, 3};
    vecs[18] = '{0, 1, 0, 0, 0,  0, 0, 0, 1, 1, 0, 3};
    vecs[19] = '{0, 3, 0, 0, 0,  1, 0, 0, 1, 1, 0, 2};

    // Reset state.
    RES = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    check("rst busy", 32'(bus.busy), 0);
    check("rst quarter_out", 32'(bus.quarter_out), 0);
    check("rst halfDollar_out", 32'(bus.halfDollar_out), 0);
    check("rst done", 32'(bus.done), 0);
    check("rst fault", 32'(bus.fault), 0);
    check("rst remaining", 32'(bus.remaining), 0);
    check("rst qtr_stock", 32'(bus.qtr_stock), 8);
    check("rst half_stock", 32'(bus.half_stock), 4);
    RES = 1'b0;
    @(negedge CLK);

    for (int i = 0; i < 20; i++) begin
      if (vecs[i].pre == 1) do_reset();
      else if (vecs[i].pre == 2) do_refill();
      run_txn($sformatf("vec%0d", i), vecs[i].amt, vecs[i].start_refill,
              vecs[i].poke_cyc, vecs[i].poke_amt, vecs[i].exp_nh, vecs[i].exp_nq,
              vecs[i].exp_done, vecs[i].exp_fault, vecs[i].exp_rem,
              vecs[i].exp_q, vecs[i].exp_h);
    end

    // Fault is sticky in IDLE, survives a refill, clears on the next start.
    check("fault held in idle", 32'(bus.fault), 1);
    check("remaining held in idle", 32'(bus.remaining), 1);
    do_refill();
    check("refill qtr_stock", 32'(bus.qtr_stock), 8);
    check("refill half_stock", 32'(bus.half_stock), 4);
    check("fault after refill", 32'(bus.fault), 1);
    run_txn("clear_fault", 0, 0, 0, 0, 0, 0, 1, 0, 0, 8, 4);

    // Reset in the middle of a half-dollar pulse.
    run_txn("pre_res", 2, 0, 0, 0, 1, 0, 1, 0, 0, 8, 3);
    bus.start      = 1'b1;
    bus.change_amt = 3'd3;
    @(posedge CLK);
    @(negedge CLK);
    bus.start = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    check("mid pulse half_out", 32'(bus.halfDollar_out), 1);
    check("mid pulse half_stock", 32'(bus.half_stock), 2);
    RES = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    RES = 1'b0;
    check("res busy", 32'(bus.busy), 0);
    check("res quarter_out", 32'(bus.quarter_out), 0);
    check("res halfDollar_out", 32'(bus.halfDollar_out), 0);
    check("res done", 32'(bus.done), 0);
    check("res fault", 32'(bus.fault), 0);
    check("res remaining", 32'(bus.remaining), 0);
    check("res qtr_stock", 32'(bus.qtr_stock), 8);
    check("res half_stock", 32'(bus.half_stock), 4);
    @(negedge CLK);
    @(negedge CLK);
    check("res stays idle", 32'(bus.busy), 0);
    check("res no coin", 32'(bus.halfDollar_out), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
